// File: rtl/mult32_pkg.sv
// Shared widths, iteration count and controller state type for the mult32 multiplier.
package mult32_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ITER   = 16;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/mult32_if.sv
// Request/result bundle of the mult32 multiplier: start request, operands, product and done flag.
interface mult32_if;
    import mult32_pkg::*;

    logic              init;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic [PROD_W-1:0] pp;
    logic              done;

    modport master (
        output init,
        output A,
        output B,
        input  pp,
        input  done
    );

    modport slave (
        input  init,
        input  A,
        input  B,
        output pp,
        output done
    );

endinterface

// File: rtl/mult32_ctrl.sv
// Sequencer for mult32: IDLE/RUN/DONE FSM and iteration counter issuing load/step strobes.
// MULT32_EARLY_DONE_EN adds an exit from RUN as soon as the remaining multiplier bits are zero.
module mult32_ctrl
    import mult32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
`ifdef MULT32_EARLY_DONE_EN
    input  logic mplier_last,
`endif
    output logic load,
    output logic step,
    output logic done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (init) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = StDone;
                end
`ifdef MULT32_EARLY_DONE_EN
                // Nothing left to add once the shifted multiplier is empty.
                if (mplier_last) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                done = 1'b1;
                if (init) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/mult32.sv
// 16x16 unsigned shift-and-add multiplier, one iteration per clock, product held with done.
// Build option MULT32_EARLY_DONE_EN finishes as soon as no multiplier bits remain.
module mult32
    import mult32_pkg::*;
(
    input logic   clk,
    input logic   rst,
    mult32_if.slave bus
);

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [PROD_W-1:0] pp_q, pp_d;
    logic              load;
    logic              step;
    logic              done;

    mult32_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .init        (bus.init),
`ifdef MULT32_EARLY_DONE_EN
        .mplier_last (mplier_q[OP_W-1:1] == '0),
`endif
        .load        (load),
        .step        (step),
        .done        (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            pp_q     <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            pp_q     <= pp_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pp_d     = pp_q;
        if (load) begin
            mcand_d  = {{(PROD_W - OP_W){1'b0}}, bus.A};
            mplier_d = bus.B;
            pp_d     = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                pp_d = pp_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    assign bus.pp   = pp_q;
    assign bus.done = done;

endmodule

// File: tb/tb_mult32.sv
// Self-checking bench for mult32: behavioural product/latency model, per-cycle compare,
// directed literal cases and randomized operations.
module tb_mult32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult32_if bus_if ();

    mult32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

`ifdef MULT32_EARLY_DONE_EN
    localparam int LAT_B3    = 3;
    localparam int LAT_FA00  = 17;
    localparam int LAT_B0    = 2;
    localparam int LAT_B100  = 10;
    localparam int LAT_B9    = 5;
`else
    localparam int LAT_B3    = 17;
    localparam int LAT_FA00  = 17;
    localparam int LAT_B0    = 17;
    localparam int LAT_B100  = 17;
    localparam int LAT_B9    = 17;
`endif

    // Number of RUN iterations the model expects for multiplier b.
    function automatic int iters(input logic [15:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) hi = i + 1;
        end
`ifndef MULT32_EARLY_DONE_EN
        hi = 16;
`endif
        return (hi == 0) ? 1 : hi;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: busy countdown, then done with A*B until the next accepted request.
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_zero  = 1'b0;
    int          m_rem   = 0;
    logic [31:0] m_prod  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_zero  <= 1'b1;
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
            m_rem <= m_rem - 1;
        end else if (bus_if.init) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_zero <= 1'b0;
            m_rem  <= iters(bus_if.B);
            m_prod <= 32'(bus_if.A) * 32'(bus_if.B);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_done", 32'(bus_if.done), 32'(m_done));
            if (m_done) begin
                check("model_pp", bus_if.pp, m_prod);
            end else if (m_zero) begin
                check("model_pp_idle", bus_if.pp, 32'h0);
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input logic [31:0] exp_pp, input int exp_lat);
        int cyc;
        bit got;
        @(negedge clk);
        bus_if.init = 1'b1;
        bus_if.A    = a;
        bus_if.B    = b;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == hold) begin
                bus_if.init = 1'b0;
                bus_if.A    = 16'($urandom);
                bus_if.B    = 16'($urandom);
            end
            if (bus_if.done === 1'b1) got = 1'b1;
        end
        bus_if.init = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d clocks, expected %0d", cyc, exp_lat);
        end else begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("product", bus_if.pp, exp_pp);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        bus_if.init = 1'b0;
        bus_if.A    = '0;
        bus_if.B    = '0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_pp", bus_if.pp, 32'h0);
        check("reset_done", 32'(bus_if.done), 32'h0);

        run_op(16'h0005, 16'h0003, 2, 32'h0000_000F, LAT_B3);
        repeat (3) @(negedge clk);
        check("single_op_done", 32'(bus_if.done), 32'h1);

        run_op(16'hFA00, 16'hFA00, 1, 32'hF424_0000, LAT_FA00);
        run_op(16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001, 17);
        run_op(16'h1234, 16'h0000, 1, 32'h0, LAT_B0);
        run_op(16'h0000, 16'hFFFF, 1, 32'h0, 17);
        // Restart straight out of DONE.
        run_op(16'h0100, 16'h0100, 1, 32'h0001_0000, LAT_B100);
        run_op(16'h0002, 16'h8000, 1, 32'h0001_0000, 17);

        // Abort on the 8th RUN edge.
        @(negedge clk);
        bus_if.init = 1'b1;
        bus_if.A    = 16'hBEEF;
        bus_if.B    = 16'hFFFF;
        @(negedge clk);
        bus_if.init = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_pp", bus_if.pp, 32'h0);
        check("abort_done", 32'(bus_if.done), 32'h0);
        run_op(16'd7, 16'd9, 1, 32'd63, LAT_B9);

        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 5 == 0) rb = rb >> $urandom_range(0, 15);
            run_op(ra, rb, int'($urandom_range(1, 2)), 32'(ra) * 32'(rb), 1 + iters(rb));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
